// File: rtl/prog_loader.sv
// prog_loader: receives a program as a little-endian byte stream from a UART
// receiver, assembles 32-bit words and writes them into instruction memory.
// The CPU is held while a load is in progress. A load ends successfully on
// END_WORD. It ends with an error on memory overflow, or when the byte
// stream stalls inside a partially received word.
module prog_loader #(
    parameter int          ADDR_W   = 14,
    parameter int          TIMEOUT  = 100000,
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int                 TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]    MEM_FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       buf_q, buf_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [31:0]       word;

    // The word completed by the current byte (only meaningful at index 3)
    assign word = {rx_data, buf_q};

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic: byte assembly, word commit, end/overflow/timeout
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        tmo_d   = tmo_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
            end

            S_LOAD: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: buf_d[7:0]   = rx_data;
                        2'd1: buf_d[15:8]  = rx_data;
                        2'd2: buf_d[23:16] = rx_data;
                        default: begin
                            // End marker takes priority over the overflow
                            // check, so a full memory can still end cleanly.
                            if (word == END_WORD) begin
                                state_d = S_DONE;
                            end else if (wcnt_q == MEM_FULL) begin
                                state_d = S_ERR;
                            end else begin
                                we_d    = 1'b1;
                                addr_d  = wcnt_q[ADDR_W-1:0];
                                wdata_d = word;
                                wcnt_d  = wcnt_q + (ADDR_W+1)'(1);
                            end
                        end
                    endcase
                end else if (idx_q != 2'd0) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = wcnt_q;
    assign cpu_hold   = (state_q == S_LOAD);
    assign load_done  = (state_q == S_DONE);
    assign load_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (ADDR_W=2, TIMEOUT=16).
module tb_prog_loader;

    localparam int AW  = 2;
    localparam int TMO = 16;

    logic          clock;
    logic          resetn;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    // write log filled by the negedge monitor
    int          wr_n = 0;
    logic [31:0] wr_a [0:63];
    logic [31:0] wr_d [0:63];
    int          base;

    prog_loader #(.ADDR_W(AW), .TIMEOUT(TMO), .END_WORD(32'hFFFF_FFFF)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every write pulse away from the active edge
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 64) begin
                wr_a[wr_n] = 32'(imem_addr);
                wr_d[wr_n] = imem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #12;
        chk("rst_we",    32'(imem_we),    32'd0);
        chk("rst_addr",  32'(imem_addr),  32'd0);
        chk("rst_wdata", imem_wdata,      32'd0);
        chk("rst_hold",  32'(cpu_hold),   32'd0);
        chk("rst_done",  32'(load_done),  32'd0);
        chk("rst_err",   32'(load_err),   32'd0);
        chk("rst_wcnt",  32'(word_count), 32'd0);
        resetn = 1'b1;
        tick();

        // First word written at address 0
        base = wr_n;
        pulse_start();
        chk("ld_hold", 32'(cpu_hold), 32'd1);
        send(8'h13); send(8'h00); send(8'h00); send(8'h20);
        chk("w0_we",    32'(imem_we),    32'd1);
        chk("w0_addr",  32'(imem_addr),  32'd0);
        chk("w0_wdata", imem_wdata,      32'h2000_0013);
        chk("w0_wcnt",  32'(word_count), 32'd1);
        chk("w0_hold",  32'(cpu_hold),   32'd1);
        tick();
        chk("w0_we_off",  32'(imem_we),   32'd0);
        chk("w0_hold_a",  32'(imem_addr), 32'd0);
        chk("w0_hold_d",  imem_wdata,     32'h2000_0013);

        // Two more words (second with gaps), then end marker
        for (int i = 0; i < 4; i++) begin
            send(8'h93 >> (i == 0 ? 0 : 8));
            idle(2);
        end
        send_word(32'hDEAD_BEEF);
        send_word(32'hFFFF_FFFF);
        chk("end_done", 32'(load_done),  32'd1);
        chk("end_hold", 32'(cpu_hold),   32'd0);
        chk("end_wcnt", 32'(word_count), 32'd3);
        chk("end_nwr",  32'(wr_n - base), 32'd3);
        chk("end_a0", wr_a[base],   32'd0);
        chk("end_a1", wr_a[base+1], 32'd1);
        chk("end_d1", wr_d[base+1], 32'h0000_0093);
        chk("end_a2", wr_a[base+2], 32'd2);
        chk("end_d2", wr_d[base+2], 32'hDEAD_BEEF);

        // Bytes outside LOAD are ignored
        base = wr_n;
        send_word(32'h0102_0304);
        tick();
        chk("done_nwr",  32'(wr_n - base), 32'd0);
        chk("done_wcnt", 32'(word_count),  32'd3);
        chk("done_stay", 32'(load_done),   32'd1);

        // Word boundary: no timeout at byte index 0, then a stalled word
        base = wr_n;
        pulse_start();
        chk("re_wcnt", 32'(word_count), 32'd0);
        idle(3 * TMO);
        chk("idx0_wait", 32'(cpu_hold), 32'd1);
        send(8'hAA); send(8'hBB);
        idle(TMO - 1);
        chk("tmo_early", 32'(load_err), 32'd0);
        idle(1);
        chk("tmo_err",  32'(load_err),     32'd1);
        chk("tmo_hold", 32'(cpu_hold),     32'd0);
        chk("tmo_nwr",  32'(wr_n - base),  32'd0);
        chk("tmo_wcnt", 32'(word_count),   32'd0);

        // Overflow: fifth word with a full memory
        base = wr_n;
        pulse_start();
        for (int k = 0; k < 4; k++) send_word(32'h0000_0100 + 32'(k));
        chk("ovf_a3",   32'(imem_addr),  32'd3);
        chk("ovf_w4",   32'(word_count), 32'd4);
        chk("ovf_hold", 32'(cpu_hold),   32'd1);
        send_word(32'h0000_0104);
        chk("ovf_err",  32'(load_err),    32'd1);
        chk("ovf_we",   32'(imem_we),     32'd0);
        chk("ovf_wcnt", 32'(word_count),  32'd4);
        chk("ovf_nwr",  32'(wr_n - base), 32'd4);
        chk("ovf_d3",   wr_d[base+3],     32'h0000_0103);

        // Back-to-back bytes with start held through the whole load
        base = wr_n;
        start = 1'b1;
        tick();
        send_word(32'hCAFE_0001);
        send_word(32'hCAFE_0002);
        send_word(32'hFFFF_FFFF);
        chk("b2b_done", 32'(load_done),   32'd1);
        chk("b2b_nwr",  32'(wr_n - base), 32'd2);
        chk("b2b_d0",   wr_d[base],       32'hCAFE_0001);
        chk("b2b_a1",   wr_a[base+1],     32'd1);
        chk("b2b_d1",   wr_d[base+1],     32'hCAFE_0002);
        tick();
        chk("b2b_relo", 32'(cpu_hold),   32'd1);
        chk("b2b_clr",  32'(word_count), 32'd0);
        start = 1'b0;

        // Asynchronous reset in the middle of a word
        send_word(32'h55AA_33CC);
        send(8'h01); send(8'h02);
        #2 resetn = 1'b0;
        #1;
        chk("ar_wdata", imem_wdata,       32'd0);
        chk("ar_hold",  32'(cpu_hold),    32'd0);
        chk("ar_wcnt",  32'(word_count),  32'd0);
        chk("ar_we",    32'(imem_we),     32'd0);
        idle(2);
        resetn = 1'b1;
        base = wr_n;
        send_word(32'h1234_5678);
        tick();
        chk("ar_ign_nwr",  32'(wr_n - base), 32'd0);
        chk("ar_ign_hold", 32'(cpu_hold),    32'd0);
        pulse_start();
        send_word(32'h0BAD_F00D);
        chk("ar_new_d", imem_wdata,       32'h0BAD_F00D);
        chk("ar_new_a", 32'(imem_addr),   32'd0);
        chk("ar_new_c", 32'(word_count),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
